id_ex_stage: RTL

//  Parametrised MIPS decode stage plus ID/EX pipeline register for the pipelined core.

---
 rtl/id_ex_stage.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// MIPS decode stage: register file with write-first bypass, control decode,
// immediate extension, load-use detection and the ID/EX pipeline register.

module control_unit (
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       mem_write,
   output logic       branch,
   output logic       alu_src,
   output logic       reg_dst,
   output logic [2:0] alu_control
);
   // ALU encodings: 000 and, 001 or, 010 add, 011 xor, 110 sub, 111 slt
   always_comb begin
      reg_write   = 1'b0;
      mem_to_reg  = 1'b0;
      mem_write   = 1'b0;
      branch      = 1'b0;
      alu_src     = 1'b0;
      reg_dst     = 1'b0;
      alu_control = 3'b000;
      case (op)
         6'h00: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            case (funct)
               6'h22:   alu_control = 3'b110;
               6'h24:   alu_control = 3'b000;
               6'h25:   alu_control = 3'b001;
               6'h26:   alu_control = 3'b011;
               6'h2A:   alu_control = 3'b111;
               default: alu_control = 3'b010;
            endcase
         end
         6'h23: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            mem_to_reg  = 1'b1;
            alu_control = 3'b010;
         end
         6'h2B: begin
            mem_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = 3'b010;
         end
         6'h04: begin
            branch      = 1'b1;
            alu_control = 3'b110;
         end
         6'h08: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = 3'b010;
         end
         6'h0C: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = 3'b000;
         end
         6'h0D: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = 3'b001;
         end
         6'h0E: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = 3'b011;
         end
         6'h0A: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = 3'b111;
         end
         default: ;
      endcase
   end
endmodule

module id_ex_stage #(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int PC_W       = 32,
   parameter int ZEXT_LOGIC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       InstructionD,
   input  logic [PC_W-1:0]   PCPlus4D,
   input  logic              RegWriteW,
   input  logic [REG_AW-1:0] WriteRegW,
   input  logic [DATA_W-1:0] ResultW,
   input  logic              StallE,
   input  logic              FlushE,
   output logic [REG_AW-1:0] RsD,
   output logic [REG_AW-1:0] RtD,
   output logic              LoadUseD,
   output logic              ValidE,
   output logic [PC_W-1:0]   PCPlus4E,
   output logic [DATA_W-1:0] RD1E,
   output logic [DATA_W-1:0] RD2E,
   output logic [DATA_W-1:0] ImmE,
   output logic [REG_AW-1:0] RsE,
   output logic [REG_AW-1:0] RtE,
   output logic [REG_AW-1:0] RdE,
   output logic              RegWriteE,
   output logic              MemtoRegE,
   output logic              MemWriteE,
   output logic              BranchE,
   output logic              ALUSrcE,
   output logic              RegDstE,
   output logic [2:0]        ALUControlE
);
   localparam int NREG = 2**REG_AW;

   typedef struct packed {
      logic              valid;
      logic [PC_W-1:0]   pc4;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] imm;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_to_reg;
      logic              mem_write;
      logic              branch;
      logic              alu_src;
      logic              reg_dst;
      logic [2:0]        alu_control;
   } idex_t;

   logic [DATA_W-1:0] rf [NREG];
   logic [REG_AW-1:0] rs_d, rt_d, rd_d;
   logic [DATA_W-1:0] rd1_d, rd2_d, imm_d;
   logic [5:0]        op;
   logic              zext;
   logic              wr_en;
   idex_t             d_cap, e_q;
   logic              unused_shamt;

   assign op   = InstructionD[31:26];
   assign rs_d = InstructionD[21 +: REG_AW];
   assign rt_d = InstructionD[16 +: REG_AW];
   assign rd_d = InstructionD[11 +: REG_AW];
   assign unused_shamt = ^InstructionD[10:6];

   assign wr_en = RegWriteW && (WriteRegW != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wr_en) begin
         rf[WriteRegW] <= ResultW;
      end
   end

   // Write-first: the value being written back this cycle is visible to decode now.
   always_comb begin
      rd1_d = rf[rs_d];
      if (rs_d == '0)                    rd1_d = '0;
      else if (wr_en && WriteRegW == rs_d) rd1_d = ResultW;
   end

   always_comb begin
      rd2_d = rf[rt_d];
      if (rt_d == '0)                    rd2_d = '0;
      else if (wr_en && WriteRegW == rt_d) rd2_d = ResultW;
   end

   assign zext  = (ZEXT_LOGIC != 0) && (op == 6'h0C || op == 6'h0D || op == 6'h0E);
   assign imm_d = zext ? DATA_W'(InstructionD[15:0])
                       : DATA_W'($signed(InstructionD[15:0]));

   control_unit u_ctrl (
      .op          (op),
      .funct       (InstructionD[5:0]),
      .reg_write   (d_cap.reg_write),
      .mem_to_reg  (d_cap.mem_to_reg),
      .mem_write   (d_cap.mem_write),
      .branch      (d_cap.branch),
      .alu_src     (d_cap.alu_src),
      .reg_dst     (d_cap.reg_dst),
      .alu_control (d_cap.alu_control)
   );

   assign d_cap.valid = 1'b1;
   assign d_cap.pc4   = PCPlus4D;
   assign d_cap.rd1   = rd1_d;
   assign d_cap.rd2   = rd2_d;
   assign d_cap.imm   = imm_d;
   assign d_cap.rs    = rs_d;
   assign d_cap.rt    = rt_d;
   assign d_cap.rd    = rd_d;

   // A stalled EX load is not advancing, so it cannot create a hazard this cycle.
   assign LoadUseD = e_q.valid && e_q.mem_to_reg && (e_q.rt != '0) &&
                     ((e_q.rt == rs_d) || (e_q.rt == rt_d)) && !StallE;

   always_ff @(posedge clk) begin
      if (rst || FlushE)  e_q <= '0;
      else if (!StallE)   e_q <= LoadUseD ? '0 : d_cap;
   end

   assign RsD         = rs_d;
   assign RtD         = rt_d;
   assign ValidE      = e_q.valid;
   assign PCPlus4E    = e_q.pc4;
   assign RD1E        = e_q.rd1;
   assign RD2E        = e_q.rd2;
   assign ImmE        = e_q.imm;
   assign RsE         = e_q.rs;
   assign RtE         = e_q.rt;
   assign RdE         = e_q.rd;
   assign RegWriteE   = e_q.reg_write;
   assign MemtoRegE   = e_q.mem_to_reg;
   assign MemWriteE   = e_q.mem_write;
   assign BranchE     = e_q.branch;
   assign ALUSrcE     = e_q.alu_src;
   assign RegDstE     = e_q.reg_dst;
   assign ALUControlE = e_q.alu_control;
endmodule
